stopwatch_uart_tx: RTL and testbench

// - Sends a snapshot of the 6-digit stopwatch time (BCD, MM:SS.CC) as ASCII over the board

---
 rtl/stopwatch_uart_tx_pkg.sv | 21 ++
 rtl/stopwatch_uart_tx_bcd_to_ascii.sv | 19 +
 rtl/stopwatch_uart_tx.sv | 145 ++++++++++++++
 tb/tb_stopwatch_uart_tx.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_uart_tx_pkg.sv
// Shared types and constants for the stopwatch UART transmit path.
// Contents: tx_state_t (frame FSM states) and the ASCII codes used to build
// a "MM:SS.CC[\r\n]" frame.
package sw_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    STROBE    = 3'd2,
    WAIT_DROP = 3'd3,
    WAIT_RDY  = 3'd4
  } tx_state_t;

  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_DOT   = 8'h2E;
  localparam logic [7:0] ASCII_Q     = 8'h3F;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

endpackage

// File: rtl/stopwatch_uart_tx_bcd_to_ascii.sv
// Combinational BCD digit to ASCII converter.
// Ports:
//   bcd_i   [3:0] BCD nibble
//   ascii_o [7:0] '0'..'9' for 0-9, '?' for the non-BCD codes 0xA-0xF
module bcd_to_ascii
  import sw_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [7:0] ascii_o
);

  always_comb begin
    ascii_o = ASCII_Q;
    if (bcd_i <= 4'd9) begin
      ascii_o = ASCII_0 + {4'b0000, bcd_i};
    end
  end

endmodule

// File: rtl/stopwatch_uart_tx.sv
// Stopwatch time snapshot transmitter: sends "MM:SS.CC" (plus "\r\n" when
// SEND_CRLF=1) one byte at a time over a txdata/txclk/txready UART port.
// Ports:
//   clk        system clock
//   nRst_i     synchronous active-low reset
//   send_i     one-cycle request to snapshot digits_i and send a frame
//   digits_i   [23:0] BCD time, [23:20] = minute tens ... [3:0] = centisec ones
//   txready_i  UART can accept a byte (level)
//   txdata_o   [7:0] byte on offer, stable through the txclk_o pulse
//   txclk_o    one-cycle strobe, UART latches txdata_o
//   busy_o     frame in progress
//   overrun_o  sticky: send_i seen while busy_o=1, cleared only by reset
module stopwatch_uart_tx
  import sw_pkg::*;
#(
  parameter bit SEND_CRLF = 1'b1
) (
  input  logic        clk,
  input  logic        nRst_i,
  input  logic        send_i,
  input  logic [23:0] digits_i,
  input  logic        txready_i,
  output logic [7:0]  txdata_o,
  output logic        txclk_o,
  output logic        busy_o,
  output logic        overrun_o
);

  localparam logic [3:0] LAST = SEND_CRLF ? 4'd9 : 4'd7;

  tx_state_t   state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [23:0] snap_q, snap_d;
  logic [7:0]  txdata_q, txdata_d;
  logic        overrun_q, overrun_d;

  logic [3:0]  nibble;
  logic [7:0]  digit_ascii;
  logic [7:0]  frame_byte;

  // Digit positions in the frame: 0,1 minutes; 3,4 seconds; 6,7 centiseconds.
  always_comb begin
    nibble = '0;
    case (idx_q)
      4'd0:    nibble = snap_q[23:20];
      4'd1:    nibble = snap_q[19:16];
      4'd3:    nibble = snap_q[15:12];
      4'd4:    nibble = snap_q[11:8];
      4'd6:    nibble = snap_q[7:4];
      4'd7:    nibble = snap_q[3:0];
      default: nibble = '0;
    endcase
  end

  bcd_to_ascii u_bcd_to_ascii (
    .bcd_i   (nibble),
    .ascii_o (digit_ascii)
  );

  always_comb begin
    frame_byte = '0;
    case (idx_q)
      4'd0, 4'd1, 4'd3, 4'd4, 4'd6, 4'd7: frame_byte = digit_ascii;
      4'd2:    frame_byte = ASCII_COLON;
      4'd5:    frame_byte = ASCII_DOT;
      4'd8:    frame_byte = ASCII_CR;
      4'd9:    frame_byte = ASCII_LF;
      default: frame_byte = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    snap_d    = snap_q;
    txdata_d  = txdata_q;
    // Any request outside IDLE is dropped, including the cycle busy_o falls.
    overrun_d = overrun_q | (send_i & (state_q != IDLE));

    case (state_q)
      IDLE: begin
        if (send_i) begin
          snap_d  = digits_i;
          idx_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (idx_q > LAST) begin
          state_d = IDLE;
        end else begin
          txdata_d = frame_byte;
          if (txready_i) begin
            state_d = STROBE;
          end
        end
      end
      STROBE: begin
        state_d = WAIT_DROP;
      end
      WAIT_DROP: begin
        // Wait for the UART to acknowledge by dropping ready, so one ready
        // window never sees two strobes.
        if (!txready_i) begin
          state_d = WAIT_RDY;
        end
      end
      WAIT_RDY: begin
        if (txready_i) begin
          if (idx_q >= LAST) begin
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = LOAD;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nRst_i) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      snap_q    <= '0;
      txdata_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      snap_q    <= snap_d;
      txdata_q  <= txdata_d;
      overrun_q <= overrun_d;
    end
  end

  assign txdata_o  = txdata_q;
  assign txclk_o   = (state_q == STROBE);
  assign busy_o    = (state_q != IDLE);
  assign overrun_o = overrun_q;

endmodule

// File: tb/tb_stopwatch_uart_tx.sv
// Directed bench for stopwatch_uart_tx: one instance with CR/LF, one without.
module tb_stopwatch_uart_tx;

  logic        clk = 1'b0;
  logic        nrst;
  logic        send_a, send_b;
  logic [23:0] digits_a, digits_b;
  logic        rdy_a, rdy_b;
  logic [7:0]  txdata_a, txdata_b;
  logic        txclk_a, txclk_b;
  logic        busy_a, busy_b;
  logic        ovr_a, ovr_b;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] cap [0:15];
  int         cap_n;
  int         cap_first;

  logic [7:0] exp_crlf [0:9] = '{8'h30, 8'h31, 8'h3A, 8'h32, 8'h33,
                                 8'h2E, 8'h34, 8'h35, 8'h0D, 8'h0A};
  logic [7:0] exp_q    [0:7] = '{8'h30, 8'h3F, 8'h3A, 8'h30, 8'h30,
                                 8'h2E, 8'h30, 8'h30};

  always #5 clk = ~clk;

  stopwatch_uart_tx #(.SEND_CRLF(1'b1)) u_dut_a (
    .clk       (clk),
    .nRst_i    (nrst),
    .send_i    (send_a),
    .digits_i  (digits_a),
    .txready_i (rdy_a),
    .txdata_o  (txdata_a),
    .txclk_o   (txclk_a),
    .busy_o    (busy_a),
    .overrun_o (ovr_a)
  );

  stopwatch_uart_tx #(.SEND_CRLF(1'b0)) u_dut_b (
    .clk       (clk),
    .nRst_i    (nrst),
    .send_i    (send_b),
    .digits_i  (digits_b),
    .txready_i (rdy_b),
    .txdata_o  (txdata_b),
    .txclk_o   (txclk_b),
    .busy_o    (busy_b),
    .overrun_o (ovr_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_rdy(input bit which, input logic v);
    if (which) rdy_b = v;
    else       rdy_a = v;
  endtask

  // Behaves like the UART: after each strobe ready stays low for two cycles.
  task automatic collect(input bit which, input int n_exp);
    int cyc = 0;
    int low = 0;
    bit done = 1'b0;
    cap_n = 0;
    cap_first = -1;
    while (cyc < 400 && !done) begin
      @(negedge clk);
      cyc++;
      if (which ? txclk_b : txclk_a) begin
        if (cap_n < 16) cap[cap_n] = which ? txdata_b : txdata_a;
        if (cap_n == 0) cap_first = cyc + 1;
        cap_n++;
        set_rdy(which, 1'b0);
        low = 1;
      end else if (low == 1) begin
        low = 2;
      end else if (low == 2) begin
        set_rdy(which, 1'b1);
        low = 0;
      end
      if (cap_n >= n_exp && !(which ? busy_b : busy_a)) done = 1'b1;
    end
    chk("frame_done", done, 1);
  endtask

  task automatic pulse_send_a();
    send_a = 1'b1;
    @(negedge clk);
    send_a = 1'b0;
  endtask

  initial begin
    int strobes;
    int low;
    bit hit;

    nrst = 1'b0;
    send_a = 1'b0; send_b = 1'b0;
    digits_a = '0; digits_b = '0;
    rdy_a = 1'b1; rdy_b = 1'b1;

    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_txclk", txclk_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_overrun", ovr_a, 0);
    chk("rst_txdata", txdata_a, 8'h00);
    chk("rst_busy_b", busy_b, 0);
    nrst = 1'b1;
    @(negedge clk);

    // Full CR/LF frame
    digits_a = 24'h012345;
    pulse_send_a();
    chk("busy_after_send", busy_a, 1);
    collect(1'b0, 10);
    chk("first_strobe_lat", cap_first, 2);
    chk("crlf_count", cap_n, 10);
    for (int i = 0; i < 10; i++) chk($sformatf("crlf_byte%0d", i), cap[i], exp_crlf[i]);
    chk("busy_fell", busy_a, 0);
    chk("no_overrun", ovr_a, 0);

    // Ready held low: no strobe, first byte waits on the bus
    rdy_a = 1'b0;
    pulse_send_a();
    strobes = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (txclk_a) strobes++;
    end
    chk("stall_strobes", strobes, 0);
    chk("stall_txdata", txdata_a, 8'h30);
    chk("stall_busy", busy_a, 1);
    rdy_a = 1'b1;
    collect(1'b0, 10);
    chk("stall_count", cap_n, 10);
    chk("stall_byte0", cap[0], 8'h30);

    // Snapshot isolation and overrun
    digits_a = 24'h012345;
    pulse_send_a();
    fork
      collect(1'b0, 10);
      begin
        repeat (6) @(negedge clk);
        digits_a = 24'h999999;
        send_a = 1'b1;
        @(negedge clk);
        send_a = 1'b0;
      end
    join
    chk("snap_count", cap_n, 10);
    for (int i = 0; i < 8; i++) chk($sformatf("snap_byte%0d", i), cap[i], exp_crlf[i]);
    chk("overrun_set", ovr_a, 1);
    repeat (5) @(negedge clk);
    chk("overrun_sticky", ovr_a, 1);
    chk("overrun_idle", busy_a, 0);

    // Non-BCD nibble, no CR/LF
    digits_b = 24'h0A0000;
    send_b = 1'b1;
    @(negedge clk);
    send_b = 1'b0;
    collect(1'b1, 8);
    chk("nocrlf_count", cap_n, 8);
    for (int i = 0; i < 8; i++) chk($sformatf("nocrlf_byte%0d", i), cap[i], exp_q[i]);

    // Reset in WAIT_DROP of the fourth byte
    digits_a = 24'h012345;
    rdy_a = 1'b1;
    pulse_send_a();
    strobes = 0;
    low = 0;
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      if (txclk_a) begin
        strobes++;
        rdy_a = 1'b0;
        low = 1;
        if (strobes == 4) begin
          @(negedge clk);
          nrst = 1'b0;
          hit = 1'b1;
        end
      end else if (low == 1) begin
        low = 2;
      end else if (low == 2) begin
        rdy_a = 1'b1;
        low = 0;
      end
    end
    chk("midrst_reached", hit, 1);
    @(negedge clk);
    chk("midrst_busy", busy_a, 0);
    chk("midrst_txclk", txclk_a, 0);
    chk("midrst_overrun", ovr_a, 0);
    chk("midrst_txdata", txdata_a, 8'h00);
    nrst = 1'b1;
    rdy_a = 1'b1;
    @(negedge clk);
    pulse_send_a();
    collect(1'b0, 10);
    chk("restart_count", cap_n, 10);
    chk("restart_byte0", cap[0], 8'h30);
    chk("restart_byte3", cap[3], 8'h32);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
